// File: rtl/mac_pkg.sv
// mac_pkg: shared types and width helpers for the MAC feeder slice
package mac_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  typedef enum logic [2:0] {
    CLEAR   = 3'd0,
    ACCUM   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4
  } feeder_state_t;
  function automatic int ACC_W(input int dw);
    return 3 * dw;
  endfunction
endpackage

// File: rtl/operand_fifo.sv
// operand_fifo: synchronous FIFO of operand pairs, registered pointers and count
module operand_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/mac_vec_feeder.sv
// mac_vec_feeder: buffers operand pairs and sequences one MAC through VEC_LEN-long dot products
module mac_vec_feeder
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int VEC_LEN    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_a,
  input  logic [DATA_WIDTH-1:0]           in_b,
  output logic                            mac_en,
  output logic                            mac_clr,
  output logic [DATA_WIDTH-1:0]           mac_a,
  output logic [DATA_WIDTH-1:0]           mac_b,
  input  logic [ACC_W(DATA_WIDTH)-1:0]    mac_cout,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [ACC_W(DATA_WIDTH)-1:0]    res_data
);
  localparam int RW = ACC_W(DATA_WIDTH);
  localparam int CW = $clog2(VEC_LEN);
  feeder_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mac_en_q, mac_clr_q, res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic [RW-1:0] res_data_q, res_data_d;
  logic [2*DATA_WIDTH-1:0] fifo_dout;
  logic fifo_full, fifo_empty, pop, last;
  logic [$clog2(FIFO_DEPTH):0] fifo_level_unused;
  operand_fifo #(.WIDTH(2*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(in_valid),
    .din_i({in_a, in_b}),
    .pop_i(pop),
    .dout_o(fifo_dout),
    .full_o(fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_level_unused)
  );
  assign in_ready = !fifo_full;
  assign pop      = state_q == ACCUM && !fifo_empty;
  assign last     = cnt_q == CW'(VEC_LEN - 1);
  always_comb begin
    state_d = state_q == CLEAR   ? ACCUM :
              state_q == ACCUM   ? (pop && last ? WAIT : ACCUM) :
              state_q == WAIT    ? CAPTURE :
              state_q == CAPTURE ? HOLD :
              state_q == HOLD    ? (res_ready ? CLEAR : HOLD) : CLEAR;
    cnt_d = state_q == CLEAR ? '0 : pop ? cnt_q + CW'(1) : cnt_q;
    {mac_a_d, mac_b_d} = pop ? fifo_dout : {mac_a_q, mac_b_q};
    res_data_d = state_q == CAPTURE ? mac_cout : res_data_q;
    res_valid_d = state_q == CAPTURE || (res_valid_q && !res_ready);
  end
  // mac_en follows the pop by one edge; the MAC folds the pair in on the edge after
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mac_en_q    <= pop;
      mac_clr_q   <= state_q == CLEAR;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end
  assign mac_en    = mac_en_q;
  assign mac_clr   = mac_clr_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
endmodule
